wb_addr_dec: RTL and testbench
==============================

Name: wb_addr_dec

Overview:
Parametrised Wishbone address decoder and ack generator for the SoC data bus, the successor to the single-slave match/ack cell.
- Decodes one master address against N_SLAVE base/mask windows and drives a one-hot slave enable.
- Per slave, either generates ack locally after a programmable wait count, or forwards the slave's own ack under a timeout.
- Unmapped accesses and timed-out accesses terminate with an error pulse, so the CPU never hangs.

Parameters:
ADDR_W, 8, width of decoded address field
N_SLAVE, 4, number of slave windows (1..8)
BASE, {N_SLAVE{ADDR_W'h0}}, packed per-slave base addresses; slave i occupies bits [i*ADDR_W +: ADDR_W]
MASK, {N_SLAVE{ADDR_W'hFF}}, packed per-slave compare masks
WAIT, {N_SLAVE{4'h0}}, packed 4-bit local wait states per slave
EXT_ACK, {N_SLAVE{1'b0}}, bit i = 1: slave i supplies its own ack
TIMEOUT, 16, cycles allowed for an external ack (2..255)

Ports:
wb_clk  in  1  bus clock
wb_rst_n  in  1  asynchronous active-low reset
addr  in  ADDR_W  master address field
wb_cyc  in  1  master cycle/strobe
s_ack  in  N_SLAVE  per-slave ack; used only where EXT_ACK bit is set
en  out  N_SLAVE  one-hot slave enable
ack  out  1  transfer-complete pulse to master
err  out  1  error-termination pulse to master
busy  out  1  high while a transfer is in progress

Behaviour:
- Reset (async assert, sync release on wb_clk): state=IDLE; ack=0; err=0; busy=0; en=0; counters=0.
- Decode: hit_i = ((addr & MASK_i) == (BASE_i & MASK_i)). The lowest index wins on overlap. sel = index of the winning hit. miss = no hit.
- en[i] = wb_cyc & hit_i & (i==sel) & (state in {IDLE, WAIT}). en is combinational, so the slave sees it in the request cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE, wb_cyc=1, miss: err<=1, go to RESP.
- IDLE, wb_cyc=1, hit, local slave with WAIT_sel=0: ack<=1, go to RESP. Latency 1 cycle, matching the previous cell.
- IDLE, wb_cyc=1, otherwise: latch sel, load cnt (WAIT_sel-1 for a local slave, TIMEOUT-1 for an external slave), go to WAIT. busy=1.
- WAIT, local slave: decrement cnt; at cnt==0, ack<=1 and go to RESP. Total latency = WAIT_sel+1 cycles.
- WAIT, external slave: s_ack[sel]=1 gives ack<=1 next edge and goes to RESP. If cnt reaches 0 with no s_ack, err<=1 and go to RESP.
- If s_ack arrives in the same cycle cnt hits 0, ack wins and err stays 0.
- RESP: ack/err is high for exactly this one cycle. Clear both and return to IDLE unconditionally. en=0, busy=1.
- A master still holding wb_cyc in the following IDLE cycle starts a new transfer (no continuous re-ack).
- ack and err are never high together.
- Abort: wb_cyc=0 in WAIT returns to IDLE next edge with no ack/err. A late s_ack is ignored.
- s_ack on a non-selected or local slave is ignored.
- An address change during WAIT is ignored: sel stays latched, and en tracks the latched sel gated with wb_cyc.
- Async reset mid-transfer: all outputs drop immediately and no pulse is emitted after release.

Optional Feature:
WB_ADDR_DEC_STATS_EN
- Defined: adds two outputs, ack_count[15:0] and err_count[15:0].
- Each counter increments on its RESP pulse and saturates at 16'hFFFF.
- Both clear on reset, or when wb_cyc=1 with addr==BASE_0 while sel=0 and a local ack completes with the STATS_CLR bit (addr LSB)... not used. Reset-only clear.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: BASE={8'h30,8'h20,8'h10,8'h00}, WAIT=0, wb_rst_n=0 mid-simulation -> ack/err/en/busy=0 asynchronously.
- Local zero-wait: addr=8'h10, wb_cyc=1 -> en=4'b0010 in the request cycle; ack high exactly 1 cycle later for 1 cycle; next IDLE cycle re-requests if cyc is held.
- Local wait: WAIT_2=3, addr=8'h20 -> ack at cycle 4 after the request; en=4'b0100 for cycles 0..3.
- External ack: EXT_ACK=4'b1000, s_ack[3] raised 5 cycles after the request -> ack 1 cycle later, err=0. With no s_ack, TIMEOUT=16 -> err pulse 16 cycles after the request.
- Unmapped and abort: addr=8'h7F -> err 1 cycle later, en=0. Dropping wb_cyc during WAIT -> IDLE, no ack/err; the next transfer decodes normally.
- Stats (with WB_ADDR_DEC_STATS_EN): 3 acks and 2 errs -> ack_count=3, err_count=2. Preloaded via force to 16'hFFFF -> holds at 16'hFFFF.

Source files
------------

// File: rtl/wb_addr_dec.sv
// Wishbone address decoder with per-slave local/external ack generation and error termination.
// Optional ack/err statistics counters are enabled with `define WB_ADDR_DEC_STATS_EN.
`timescale 1ns/1ps
module wb_addr_dec #(
  parameter int unsigned                 ADDR_W  = 8,
  parameter int unsigned                 N_SLAVE = 4,
  parameter logic [N_SLAVE*ADDR_W-1:0]   BASE    = '0,
  parameter logic [N_SLAVE*ADDR_W-1:0]   MASK    = '1,
  parameter logic [N_SLAVE*4-1:0]        WAIT    = '0,
  parameter logic [N_SLAVE-1:0]          EXT_ACK = '0,
  parameter int unsigned                 TIMEOUT = 16
) (
  input  logic               wb_clk,
  input  logic               wb_rst_n,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               wb_cyc,
  input  logic [N_SLAVE-1:0] s_ack,
  output logic [N_SLAVE-1:0] en,
  output logic               ack,
  output logic               err,
  output logic               busy
`ifdef WB_ADDR_DEC_STATS_EN
  ,
  output logic [15:0]        ack_count,
  output logic [15:0]        err_count
`endif
);

  localparam int unsigned SEL_W = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;

  logic [N_SLAVE-1:0] hit;
  logic               dec_hit;
  logic [SEL_W-1:0]   dec_sel;
  logic [3:0]         dec_wait;
  logic               dec_ext;
  logic               sel_ext;

  // Address decode; the lowest matching window wins.
  always_comb begin
    hit     = '0;
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int unsigned i = 0; i < N_SLAVE; i++) begin
      hit[i] = ((addr & MASK[i*ADDR_W +: ADDR_W]) ==
                (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W]));
      if (hit[i] && !dec_hit) begin
        dec_hit = 1'b1;
        dec_sel = SEL_W'(i);
      end
    end
  end

  always_comb begin
    dec_wait = WAIT[int'(dec_sel)*4 +: 4];
    dec_ext  = EXT_ACK[dec_sel];
    sel_ext  = EXT_ACK[sel_q];
  end

  // Enable follows the live decode in IDLE and the latched slave in WAIT.
  always_comb begin
    en = '0;
    if (wb_rst_n && wb_cyc) begin
      if (state_q == S_IDLE && dec_hit) begin
        en[dec_sel] = 1'b1;
      end else if (state_q == S_WAIT) begin
        en[sel_q] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_cyc) begin
          if (!dec_hit) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (!dec_ext && dec_wait == 4'h0) begin
            ack_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            sel_d   = dec_sel;
            cnt_d   = dec_ext ? 8'(TIMEOUT - 1) : ({4'h0, dec_wait} - 8'd1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (sel_ext) begin
          // Timeout fires on the edge where cnt steps down to zero; a
          // concurrent slave ack takes priority.
          if (s_ack[sel_q]) begin
            ack_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_RESP;
          end else if (cnt_q <= 8'd1) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else if (cnt_q == 8'd0) begin
          ack_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ack  = ack_q;
    err  = err_q;
    busy = (state_q != S_IDLE);
  end

`ifdef WB_ADDR_DEC_STATS_EN
  logic [15:0] ack_count_q, ack_count_d;
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    ack_count_d = ack_count_q;
    err_count_d = err_count_q;
    if (ack_q && ack_count_q != '1) ack_count_d = ack_count_q + 16'd1;
    if (err_q && err_count_q != '1) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_count_q <= '0;
      err_count_q <= '0;
    end else begin
      ack_count_q <= ack_count_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    ack_count = ack_count_q;
    err_count = err_count_q;
  end
`endif

endmodule

// File: tb/tb_wb_addr_dec.sv
// Randomised self-checking bench for wb_addr_dec against a transfer-level latency model.
`timescale 1ns/1ps
module tb_wb_addr_dec;

  localparam int T_OUT = 16;

  logic       wb_clk;
  logic       wb_rst_n;
  logic [7:0] addr;
  logic       wb_cyc;
  logic [3:0] s_ack;
  logic [3:0] en;
  logic       ack;
  logic       err;
  logic       busy;
`ifdef WB_ADDR_DEC_STATS_EN
  logic [15:0] ack_count;
  logic [15:0] err_count;
`endif

  int checks = 0;
  int errors = 0;
  int n_ack  = 0;
  int n_err  = 0;

  // Slave map as seen by the model: base, wait states, external-ack flag.
  int m_base [4] = '{8'h00, 8'h10, 8'h20, 8'h30};
  int m_wait [4] = '{0, 0, 3, 0};
  int m_ext  [4] = '{0, 0, 0, 1};

  wb_addr_dec #(
    .ADDR_W (8),
    .N_SLAVE(4),
    .BASE   ({8'h30, 8'h20, 8'h10, 8'h00}),
    .MASK   ({4{8'hFF}}),
    .WAIT   ({4'h0, 4'h3, 4'h0, 4'h0}),
    .EXT_ACK(4'b1000),
    .TIMEOUT(T_OUT)
  ) dut (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .addr    (addr),
    .wb_cyc  (wb_cyc),
    .s_ack   (s_ack),
    .en      (en),
    .ack     (ack),
    .err     (err),
    .busy    (busy)
`ifdef WB_ADDR_DEC_STATS_EN
    ,
    .ack_count(ack_count),
    .err_count(err_count)
`endif
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  function automatic int model_decode(input logic [7:0] a);
    for (int i = 0; i < 4; i++) if (int'(a) == m_base[i]) return i;
    return -1;
  endfunction

  // One transfer: request in cycle 0, s_ack[3] raised only in cycle k.
  // Expected completion cycle comes from the decode/wait/timeout rules.
  task automatic do_xfer(input logic [7:0] a, input int k, input bit hold_after);
    int sel, lat;
    bit is_err;
    logic [3:0] exp_en;
    sel = model_decode(a);
    if (sel < 0) begin
      is_err = 1; lat = 1;
    end else if (m_ext[sel] == 0) begin
      is_err = 0; lat = m_wait[sel] + 1;
    end else if (k >= 1 && k <= T_OUT - 1) begin
      is_err = 0; lat = k + 1;
    end else begin
      is_err = 1; lat = T_OUT;
    end
    addr   = a;
    wb_cyc = 1'b1;
    s_ack  = 4'($urandom_range(0, 15));
    if (sel == 3) s_ack[3] = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      @(negedge wb_clk);
      exp_en = (c < lat && sel >= 0) ? 4'(1 << sel) : 4'b0000;
      checks++;
      if (en !== exp_en) begin
        errors++;
        $display("FAIL en addr=%h cyc=%0d got=%b exp=%b", a, c, en, exp_en);
      end
      checks++;
      if (ack !== (c == lat && !is_err)) begin
        errors++;
        $display("FAIL ack addr=%h cyc=%0d got=%b exp=%b", a, c, ack, (c == lat && !is_err));
      end
      checks++;
      if (err !== (c == lat && is_err)) begin
        errors++;
        $display("FAIL err addr=%h cyc=%0d got=%b exp=%b", a, c, err, (c == lat && is_err));
      end
      checks++;
      if (busy !== (c > 0)) begin
        errors++;
        $display("FAIL busy addr=%h cyc=%0d got=%b exp=%b", a, c, busy, (c > 0));
      end
      @(posedge wb_clk); #1;
      if (c < lat) begin
        addr  = 8'($urandom_range(0, 255));
        s_ack = 4'($urandom_range(0, 15));
        if (sel == 3) s_ack[3] = (c + 1 == k);
      end
    end
    wb_cyc = hold_after;
    s_ack  = '0;
    if (is_err) n_err++; else n_ack++;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge wb_clk);
      checks++;
      if ({en, ack, err, busy} !== 7'b0) begin
        errors++;
        $display("FAIL idle en/ack/err/busy got=%b exp=0000000", {en, ack, err, busy});
      end
      @(posedge wb_clk); #1;
    end
  endtask

  task automatic test_reset;
    wb_rst_n = 1'b0; wb_cyc = 1'b0; addr = '0; s_ack = '0;
    #2;
    checks++;
    if ({en, ack, err, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_initial got=%b exp=0000000", {en, ack, err, busy});
    end
    @(negedge wb_clk); wb_rst_n = 1'b1;
    @(posedge wb_clk); #1;
    addr = 8'h20; wb_cyc = 1'b1;
    @(posedge wb_clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_busy got=%b exp=1", busy);
    end
    #3 wb_rst_n = 1'b0;
    #1;
    checks++;
    if ({en, ack, err, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=0000000", {en, ack, err, busy});
    end
    wb_cyc = 1'b0;
    @(negedge wb_clk); wb_rst_n = 1'b1;
    n_ack = 0; n_err = 0;
    @(posedge wb_clk); #1;
    idle(5);
  endtask

  task automatic test_local;
    do_xfer(8'h10, 0, 1'b1);
    do_xfer(8'h10, 0, 1'b0);
    idle(1);
    do_xfer(8'h20, 0, 1'b0);
    idle(1);
    do_xfer(8'h00, 0, 1'b0);
    idle(1);
  endtask

  task automatic test_external;
    do_xfer(8'h30, 5, 1'b0);
    idle(1);
    do_xfer(8'h30, 0, 1'b0);
    idle(1);
    do_xfer(8'h30, T_OUT - 1, 1'b0);
    idle(1);
    do_xfer(8'h30, T_OUT, 1'b0);
    idle(1);
    do_xfer(8'h30, 1, 1'b0);
    idle(1);
  endtask

  task automatic test_unmapped;
    do_xfer(8'h7F, 0, 1'b0);
    idle(1);
    do_xfer(8'h11, 0, 1'b0);
    idle(1);
  endtask

  task automatic test_abort;
    addr = 8'h20; wb_cyc = 1'b1;
    @(negedge wb_clk);
    checks++;
    if (en !== 4'b0100) begin
      errors++;
      $display("FAIL abort_en0 got=%b exp=0100", en);
    end
    @(posedge wb_clk); #1;
    @(posedge wb_clk); #1;
    wb_cyc = 1'b0;
    @(negedge wb_clk);
    checks++;
    if ({en, ack, err, busy} !== 7'b0000001) begin
      errors++;
      $display("FAIL abort_drop got=%b exp=0000001", {en, ack, err, busy});
    end
    @(posedge wb_clk); #1;
    idle(3);
    addr = 8'h30; wb_cyc = 1'b1;
    @(posedge wb_clk); #1;
    wb_cyc = 1'b0;
    @(posedge wb_clk); #1;
    s_ack = 4'b1000;
    idle(3);
    s_ack = '0;
    do_xfer(8'h10, 0, 1'b0);
    idle(1);
  endtask

  task automatic test_back_to_back;
    do_xfer(8'h10, 0, 1'b1);
    do_xfer(8'h10, 0, 1'b1);
    do_xfer(8'h20, 0, 1'b1);
    do_xfer(8'h7F, 0, 1'b1);
    do_xfer(8'h30, 3, 1'b1);
    do_xfer(8'h00, 0, 1'b0);
    idle(2);
  endtask

  task automatic test_random;
    logic [7:0] a;
    int pick;
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 4);
      a = (pick < 4) ? 8'(pick * 16) : 8'($urandom_range(0, 255));
      do_xfer(a, $urandom_range(1, T_OUT + 3), 1'($urandom_range(0, 1)));
      if (wb_cyc == 1'b0) idle($urandom_range(0, 2));
    end
    wb_cyc = 1'b0;
    idle(2);
  endtask

`ifdef WB_ADDR_DEC_STATS_EN
  task automatic test_stats;
    checks++;
    if (ack_count !== 16'(n_ack)) begin
      errors++;
      $display("FAIL stats_ack got=%0d exp=%0d", ack_count, n_ack);
    end
    checks++;
    if (err_count !== 16'(n_err)) begin
      errors++;
      $display("FAIL stats_err got=%0d exp=%0d", err_count, n_err);
    end
    force dut.ack_count_q = 16'hFFFF;
    force dut.err_count_q = 16'hFFFF;
    #2;
    release dut.ack_count_q;
    release dut.err_count_q;
    @(posedge wb_clk); #1;
    do_xfer(8'h10, 0, 1'b0);
    do_xfer(8'h7F, 0, 1'b0);
    idle(1);
    checks++;
    if (ack_count !== 16'hFFFF || err_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_sat got=%h/%h exp=ffff/ffff", ack_count, err_count);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_local();
    test_external();
    test_unmapped();
    test_abort();
    test_back_to_back();
    test_random();
`ifdef WB_ADDR_DEC_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
